// File: rtl/ddr_cmd_driver_if.sv
// Request bundle between the scheduler and ddr_cmd_driver.
// master = scheduler (drives request), slave = driver (returns req_ready).
interface ddr_cmd_driver_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_type;
    logic [1:0]  req_bg;
    logic [1:0]  req_ba;
    logic [16:0] req_row;
    logic [9:0]  req_col;
    logic [63:0] req_wdata;
    logic        req_bl8;

    modport master (
        output req_valid, req_type, req_bg, req_ba,
        output req_row, req_col, req_wdata, req_bl8,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_type, req_bg, req_ba,
        input  req_row, req_col, req_wdata, req_bl8,
        output req_ready
    );
endinterface

// File: rtl/ddr_cmd_driver.sv
// ddr_cmd_driver: DDR4 command/address driver plus write preamble and
// BL8/BL4 burst as rise/fall byte pairs. One request in flight at a time.
// Ports: CK_t, reset (sync, active-high); req (slave request bundle);
// command pins cs_n..WE_n_A14, address pins A13..A9_A0, bg_addr, ba_addr;
// dq_rise/dq_fall/dq_oe/dqs_en/wr_done toward the PHY.
// Option: DDR_CMD_PARITY_EN adds the even-parity output PAR.
module ddr_cmd_driver #(
    parameter int CWL    = 9,
    parameter int TRCD   = 4,
    parameter int RD_GAP = 4
) (
    input  logic        CK_t,
    input  logic        reset,
    ddr_cmd_driver_if.slave req,
    output logic        cs_n,
    output logic        act_n,
    output logic        RAS_n_A16,
    output logic        CAS_n_A15,
    output logic        WE_n_A14,
`ifdef DDR_CMD_PARITY_EN
    output logic        PAR,
`endif
    output logic        A13,
    output logic        A12_BC_n,
    output logic        A11,
    output logic        A10_AP,
    output logic [9:0]  A9_A0,
    output logic [1:0]  bg_addr,
    output logic [1:0]  ba_addr,
    output logic [7:0]  dq_rise,
    output logic [7:0]  dq_fall,
    output logic        dq_oe,
    output logic        dqs_en,
    output logic        wr_done
);

    typedef enum logic [2:0] {
        IDLE, CMD, TRCD_WAIT, WR_LAT, PRE, BURST, RD_WAIT
    } state_t;

    localparam logic [1:0] T_ACT = 2'b00;
    localparam logic [1:0] T_WR  = 2'b01;
    localparam logic [1:0] T_RD  = 2'b10;

    localparam logic [4:0] CMD_NOP = 5'b11111;
    localparam logic [4:0] CMD_WR  = 5'b01100;
    localparam logic [4:0] CMD_RD  = 5'b01101;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  beat_q, beat_d, beat_nx, last_beat;
    logic [1:0]  type_q, type_d;
    logic        bl8_q, bl8_d;
    logic [63:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic [4:0]  cmd_q, cmd_d;
    logic [13:0] addr_q, addr_d;
    logic [1:0]  bg_q, bg_d;
    logic [1:0]  ba_q, ba_d;
    logic        oe_q, oe_d;
    logic        dqs_q, dqs_d;
    logic        done_q, done_d;
    logic [7:0]  rise_q, rise_d;
    logic [7:0]  fall_q, fall_d;
`ifdef DDR_CMD_PARITY_EN
    logic        par_q, par_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        beat_d    = beat_q;
        type_d    = type_q;
        bl8_d     = bl8_q;
        wdata_d   = wdata_q;
        ready_d   = 1'b0;
        cmd_d     = CMD_NOP;
        addr_d    = '0;
        bg_d      = '0;
        ba_d      = '0;
        oe_d      = 1'b0;
        dqs_d     = 1'b0;
        done_d    = 1'b0;
        rise_d    = '0;
        fall_d    = '0;
        beat_nx   = beat_q + 2'd1;
        last_beat = bl8_q ? 2'd3 : 2'd1;

        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (req.req_valid && ready_q) begin
                    ready_d = 1'b0;
                    state_d = CMD;
                    type_d  = req.req_type;
                    bl8_d   = req.req_bl8;
                    wdata_d = req.req_wdata;
                    // Command goes to the pins in the cycle after accept.
                    case (req.req_type)
                        T_ACT: begin
                            cmd_d  = {2'b00, req.req_row[16:14]};
                            addr_d = req.req_row[13:0];
                            bg_d   = req.req_bg;
                            ba_d   = req.req_ba;
                        end
                        T_WR, T_RD: begin
                            cmd_d  = (req.req_type == T_WR) ? CMD_WR : CMD_RD;
                            addr_d = {1'b0, req.req_bl8, 2'b00, req.req_col};
                            bg_d   = req.req_bg;
                            ba_d   = req.req_ba;
                        end
                        default: ;
                    endcase
                end
            end
            CMD: begin
                // cnt holds the wait cycles remaining after the current one.
                unique case (type_q)
                    T_ACT: begin
                        if (TRCD > 1) begin
                            state_d = TRCD_WAIT;
                            cnt_d   = 8'(TRCD - 2);
                        end else begin
                            state_d = IDLE;
                            ready_d = 1'b1;
                        end
                    end
                    T_WR: begin
                        if (CWL > 2) begin
                            state_d = WR_LAT;
                            cnt_d   = 8'(CWL - 3);
                        end else begin
                            state_d = PRE;
                            dqs_d   = 1'b1;
                        end
                    end
                    T_RD: begin
                        if (RD_GAP > 1) begin
                            state_d = RD_WAIT;
                            cnt_d   = 8'(RD_GAP - 2);
                        end else begin
                            state_d = IDLE;
                            ready_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                    end
                endcase
            end
            TRCD_WAIT, RD_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            WR_LAT: begin
                if (cnt_q == 8'd0) begin
                    state_d = PRE;
                    dqs_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            PRE: begin
                state_d = BURST;
                beat_d  = 2'd0;
                oe_d    = 1'b1;
                dqs_d   = 1'b1;
                rise_d  = wdata_q[7:0];
                fall_d  = wdata_q[15:8];
            end
            BURST: begin
                if (beat_q == last_beat) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else begin
                    beat_d = beat_nx;
                    oe_d   = 1'b1;
                    dqs_d  = 1'b1;
                    rise_d = wdata_q[{beat_nx, 4'b0000} +: 8];
                    fall_d = wdata_q[{beat_nx, 4'b1000} +: 8];
                    done_d = (beat_nx == last_beat);
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

`ifdef DDR_CMD_PARITY_EN
    // NOP cycles carry all-ones commands and zero address, so this is 0.
    assign par_d = ^{cmd_d[3:0], addr_d, bg_d, ba_d};
`endif

    always_ff @(posedge CK_t) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            type_q  <= '0;
            bl8_q   <= 1'b0;
            wdata_q <= '0;
            ready_q <= 1'b1;
            cmd_q   <= CMD_NOP;
            addr_q  <= '0;
            bg_q    <= '0;
            ba_q    <= '0;
            oe_q    <= 1'b0;
            dqs_q   <= 1'b0;
            done_q  <= 1'b0;
            rise_q  <= '0;
            fall_q  <= '0;
`ifdef DDR_CMD_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            type_q  <= type_d;
            bl8_q   <= bl8_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            bg_q    <= bg_d;
            ba_q    <= ba_d;
            oe_q    <= oe_d;
            dqs_q   <= dqs_d;
            done_q  <= done_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
`ifdef DDR_CMD_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign req.req_ready = ready_q;
    assign {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14} = cmd_q;
    assign {A13, A12_BC_n, A11, A10_AP, A9_A0} = addr_q;
    assign bg_addr = bg_q;
    assign ba_addr = ba_q;
    assign dq_oe   = oe_q;
    assign dqs_en  = dqs_q;
    assign wr_done = done_q;
    assign dq_rise = rise_q;
    assign dq_fall = fall_q;
`ifdef DDR_CMD_PARITY_EN
    assign PAR = par_q;
`endif

endmodule

// File: tb/tb_ddr_cmd_driver.sv
// Self-checking bench for ddr_cmd_driver: directed scenarios plus a
// randomized request stream checked against a per-cycle expected timeline.
module tb_ddr_cmd_driver;
    localparam int CWL    = 9;
    localparam int TRCD   = 4;
    localparam int RD_GAP = 4;

    localparam logic [4:0] NOP = 5'b11111;
    localparam logic [4:0] WRC = 5'b01100;
    localparam logic [4:0] RDC = 5'b01101;

    typedef struct packed {
        logic        v;
        logic [1:0]  t;
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic [16:0] row;
        logic [9:0]  col;
        logic [63:0] wd;
        logic        bl8;
    } stim_t;

    logic CK_t = 1'b0;
    logic reset = 1'b1;
    always #5 CK_t = ~CK_t;

    ddr_cmd_driver_if bus();

    logic       cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
    logic       A13, A12_BC_n, A11, A10_AP;
    logic [9:0] A9_A0;
    logic [1:0] bg_addr, ba_addr;
    logic [7:0] dq_rise, dq_fall;
    logic       dq_oe, dqs_en, wr_done;
`ifdef DDR_CMD_PARITY_EN
    logic       PAR;
`endif

    ddr_cmd_driver #(.CWL(CWL), .TRCD(TRCD), .RD_GAP(RD_GAP)) dut (
        .CK_t(CK_t), .reset(reset), .req(bus),
        .cs_n(cs_n), .act_n(act_n), .RAS_n_A16(RAS_n_A16),
        .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14),
`ifdef DDR_CMD_PARITY_EN
        .PAR(PAR),
`endif
        .A13(A13), .A12_BC_n(A12_BC_n), .A11(A11), .A10_AP(A10_AP),
        .A9_A0(A9_A0), .bg_addr(bg_addr), .ba_addr(ba_addr),
        .dq_rise(dq_rise), .dq_fall(dq_fall), .dq_oe(dq_oe),
        .dqs_en(dqs_en), .wr_done(wr_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [42:0] obs();
        return {bus.req_ready, cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14,
                A13, A12_BC_n, A11, A10_AP, A9_A0, bg_addr, ba_addr,
                dq_oe, dqs_en, wr_done, dq_rise, dq_fall};
    endfunction

    function automatic logic [42:0] mk(
        logic rdy, logic [4:0] cmd, logic [13:0] addr,
        logic [1:0] bg, logic [1:0] ba, logic oe, logic dqs,
        logic done, logic [7:0] r, logic [7:0] f);
        return {rdy, cmd, addr, bg, ba, oe, dqs, done, r, f};
    endfunction

    function automatic stim_t mks(
        logic v, logic [1:0] t, logic [1:0] bg, logic [1:0] ba,
        logic [16:0] row, logic [9:0] col, logic [63:0] wd, logic bl8);
        stim_t s;
        s.v = v; s.t = t; s.bg = bg; s.ba = ba;
        s.row = row; s.col = col; s.wd = wd; s.bl8 = bl8;
        return s;
    endfunction

    function automatic stim_t rnd_stim(logic v);
        stim_t s;
        s.v   = v;
        s.t   = 2'($urandom_range(0, 3));
        s.bg  = 2'($urandom);
        s.ba  = 2'($urandom);
        s.row = 17'($urandom);
        s.col = 10'($urandom);
        s.wd  = {$urandom, $urandom};
        s.bl8 = 1'($urandom);
        return s;
    endfunction

    task automatic apply(stim_t s);
        bus.req_valid = s.v;
        bus.req_type  = s.t;
        bus.req_bg    = s.bg;
        bus.req_ba    = s.ba;
        bus.req_row   = s.row;
        bus.req_col   = s.col;
        bus.req_wdata = s.wd;
        bus.req_bl8   = s.bl8;
    endtask

    task automatic test_reset();
        logic [42:0] e;
        reset = 1'b1;
        apply(mks(1'b1, 2'b00, 2'd3, 2'd3, 17'h1FFFF, 10'h3FF, '1, 1'b1));
        repeat (3) @(negedge CK_t);
        e = mk(1'b1, NOP, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL reset_hold got=%h exp=%h", obs(), e);
        end
`ifdef DDR_CMD_PARITY_EN
        n_checks++;
        if (PAR !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_par got=%b exp=0", PAR);
        end
`endif
        reset = 1'b0;
        apply(rnd_stim(1'b0));
        @(negedge CK_t);
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL reset_release got=%h exp=%h", obs(), e);
        end
    endtask

    task automatic test_act();
        logic [42:0] e;
        apply(mks(1'b1, 2'b00, 2'd2, 2'd1, 17'h1ABCD, '0, '0, 1'b0));
        @(negedge CK_t);
        apply(rnd_stim(1'b0));
        e = mk(1'b0, 5'b00110, 14'h2BCD, 2'd2, 2'd1, 0, 0, 0, '0, '0);
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL act_cmd got=%h exp=%h", obs(), e);
        end
        for (int i = 1; i <= TRCD; i++) begin
            @(negedge CK_t);
            e = mk(i == TRCD, NOP, '0, '0, '0, 0, 0, 0, '0, '0);
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL act_wait C+%0d got=%h exp=%h", i, obs(), e);
            end
        end
    endtask

    task automatic test_write(logic bl8);
        logic [42:0] e;
        logic [63:0] wd;
        logic [7:0]  pr [4];
        logic [7:0]  pf [4];
        int          nb;
        int          d;
        logic        dat;
        logic [7:0]  er, ef;
        wd = 64'h8877665544332211;
        pr = '{8'h11, 8'h33, 8'h55, 8'h77};
        pf = '{8'h22, 8'h44, 8'h66, 8'h88};
        nb = bl8 ? 4 : 2;
        apply(mks(1'b1, 2'b01, 2'd1, 2'd3, '0, 10'h2A8, wd, bl8));
        @(negedge CK_t);
        apply(rnd_stim(1'b0));
        e = mk(1'b0, WRC, {1'b0, bl8, 2'b00, 10'h2A8}, 2'd1, 2'd3,
               0, 0, 0, '0, '0);
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL wr_cmd bl8=%b got=%h exp=%h", bl8, obs(), e);
        end
        for (int i = 1; i <= CWL + nb; i++) begin
            @(negedge CK_t);
            d   = i - CWL;
            dat = (d >= 0) && (d < nb);
            er  = dat ? pr[d] : 8'h00;
            ef  = dat ? pf[d] : 8'h00;
            e = mk(i == CWL + nb, NOP, '0, '0, '0, dat,
                   (i >= CWL - 1) && (i < CWL + nb),
                   i == CWL + nb - 1, er, ef);
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL wr bl8=%b C+%0d got=%h exp=%h",
                         bl8, i, obs(), e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [42:0] e;
        apply(mks(1'b1, 2'b00, 2'd0, 2'd0, 17'h00123, '0, '0, 1'b0));
        @(negedge CK_t);
        apply(mks(1'b1, 2'b10, 2'd3, 2'd2, '0, 10'h155, '0, 1'b1));
        e = mk(1'b0, 5'b00000, 14'h0123, '0, '0, 0, 0, 0, '0, '0);
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL b2b_act got=%h exp=%h", obs(), e);
        end
        for (int i = 1; i <= TRCD + 1; i++) begin
            @(negedge CK_t);
            if (i == TRCD + 1) begin
                apply(rnd_stim(1'b0));
                e = mk(1'b0, RDC, {1'b0, 1'b1, 2'b00, 10'h155}, 2'd3, 2'd2,
                       0, 0, 0, '0, '0);
            end else begin
                e = mk(i == TRCD, NOP, '0, '0, '0, 0, 0, 0, '0, '0);
            end
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL b2b C_act+%0d got=%h exp=%h", i, obs(), e);
            end
        end
        for (int j = 1; j <= RD_GAP; j++) begin
            @(negedge CK_t);
            e = mk(j == RD_GAP, NOP, '0, '0, '0, 0, 0, 0, '0, '0);
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL rd_gap C_rd+%0d got=%h exp=%h", j, obs(), e);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [42:0] e;
        logic [63:0] wd;
        wd = 64'h8877665544332211;
        apply(mks(1'b1, 2'b01, 2'd0, 2'd1, '0, 10'h2A8, wd, 1'b1));
        @(negedge CK_t);
        apply(rnd_stim(1'b0));
        repeat (10) @(negedge CK_t);
        e = mk(1'b0, NOP, '0, '0, '0, 1, 1, 0, 8'h33, 8'h44);
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL rst_mid C+10 got=%h exp=%h", obs(), e);
        end
        reset = 1'b1;
        @(negedge CK_t);
        e = mk(1'b1, NOP, '0, '0, '0, 0, 0, 0, '0, '0);
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL rst_mid C+11 got=%h exp=%h", obs(), e);
        end
        reset = 1'b0;
        @(negedge CK_t);
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL rst_mid C+12 got=%h exp=%h", obs(), e);
        end
    endtask

`ifdef DDR_CMD_PARITY_EN
    task automatic test_parity();
        apply(mks(1'b1, 2'b00, 2'd0, 2'd0, 17'h00001, '0, '0, 1'b0));
        @(negedge CK_t);
        apply(rnd_stim(1'b0));
        n_checks++;
        if (PAR !== 1'b1) begin
            n_fail++;
            $display("FAIL par_act got=%b exp=1", PAR);
        end
        @(negedge CK_t);
        n_checks++;
        if (PAR !== 1'b0) begin
            n_fail++;
            $display("FAIL par_nop got=%b exp=0", PAR);
        end
        repeat (TRCD - 1) @(negedge CK_t);
    endtask
`endif

    task automatic test_random();
        stim_t       sq[$];
        logic [42:0] eq[$];
        logic        ep[$];
        int          pos;
        int          busy_end;
        pos = 0;
        busy_end = 0;
        for (int n = 0; n < 40; n++) begin
            stim_t       r;
            int          g, vstart, acc, nb;
            logic [4:0]  cmd;
            logic [13:0] addr;
            logic [1:0]  bg, ba;
            r      = rnd_stim(1'b1);
            g      = $urandom_range(0, 2);
            vstart = pos + g;
            acc    = (busy_end > vstart) ? busy_end : vstart;
            for (int f = pos; f <= acc; f++)
                sq.push_back((f >= vstart) ? r : rnd_stim(1'b0));
            for (int f = busy_end; f <= acc; f++) begin
                eq.push_back(mk(1, NOP, '0, '0, '0, 0, 0, 0, '0, '0));
                ep.push_back(1'b0);
            end
            bg = r.bg;
            ba = r.ba;
            case (r.t)
                2'b00: begin
                    cmd  = {2'b00, r.row[16:14]};
                    addr = r.row[13:0];
                end
                2'b01: begin
                    cmd  = WRC;
                    addr = {1'b0, r.bl8, 2'b00, r.col};
                end
                2'b10: begin
                    cmd  = RDC;
                    addr = {1'b0, r.bl8, 2'b00, r.col};
                end
                default: begin
                    cmd = NOP; addr = '0; bg = '0; ba = '0;
                end
            endcase
            eq.push_back(mk(0, cmd, addr, bg, ba, 0, 0, 0, '0, '0));
            ep.push_back((cmd == NOP) ? 1'b0 : ^{cmd[3:0], addr, bg, ba});
            if (r.t == 2'b00 || r.t == 2'b10) begin
                for (int i = 1; i < ((r.t == 2'b00) ? TRCD : RD_GAP); i++) begin
                    eq.push_back(mk(0, NOP, '0, '0, '0, 0, 0, 0, '0, '0));
                    ep.push_back(1'b0);
                end
            end else if (r.t == 2'b01) begin
                nb = r.bl8 ? 4 : 2;
                for (int i = 1; i <= CWL - 2; i++) begin
                    eq.push_back(mk(0, NOP, '0, '0, '0, 0, 0, 0, '0, '0));
                    ep.push_back(1'b0);
                end
                eq.push_back(mk(0, NOP, '0, '0, '0, 0, 1, 0, '0, '0));
                ep.push_back(1'b0);
                for (int j = 0; j < nb; j++) begin
                    eq.push_back(mk(0, NOP, '0, '0, '0, 1, 1, j == nb - 1,
                                    r.wd[16*j +: 8], r.wd[16*j+8 +: 8]));
                    ep.push_back(1'b0);
                end
            end
            pos = acc + 1;
            busy_end = eq.size();
        end
        while (eq.size() < busy_end + 2) begin
            eq.push_back(mk(1, NOP, '0, '0, '0, 0, 0, 0, '0, '0));
            ep.push_back(1'b0);
        end
        while (sq.size() < eq.size()) sq.push_back(rnd_stim(1'b0));
        for (int f = 0; f < eq.size(); f++) begin
            n_checks++;
            if (obs() !== eq[f]) begin
                n_fail++;
                $display("FAIL rand frame=%0d got=%h exp=%h", f, obs(), eq[f]);
            end
`ifdef DDR_CMD_PARITY_EN
            n_checks++;
            if (PAR !== ep[f]) begin
                n_fail++;
                $display("FAIL rand_par frame=%0d got=%b exp=%b",
                         f, PAR, ep[f]);
            end
`endif
            apply(sq[f]);
            @(negedge CK_t);
        end
    endtask

    initial begin
        apply(mks(1'b0, '0, '0, '0, '0, '0, '0, 1'b0));
        test_reset();
        test_act();
        test_write(1'b1);
        test_write(1'b0);
        test_back_to_back();
        test_reset_mid_burst();
`ifdef DDR_CMD_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ddr_cmd_driver.md
# ddr_cmd_driver

Controller-side DDR4 command and write-data driver, the transmitting end of the DIMM command/DQ interface. It accepts one ACT, WR or RD request at a time from the controller scheduler and drives the encoded command/address bus for a single cycle, with NOP on all other cycles. It enforces tRCD after ACT and the write latency CWL, then emits the write preamble and the BL8 or BL4 data burst as rise/fall byte pairs for the PHY's DDR output mux.

## Interface
- CWL, 9: write latency in CK cycles from the WR command cycle to the first data cycle; must be ≥2.
- TRCD, 4: ACT-to-next-command delay in cycles; must be ≥1.
- RD_GAP, 4: cycles from the RD command cycle until a new request is accepted.

Ports, in order: name, direction, width, meaning.
- CK_t, in, 1: the only clock; all logic uses the rising edge.
- reset, in, 1: synchronous, active-high.
- req_valid, in, 1: request present.
- req_ready, out, 1: request accepted on an edge where valid and ready are both high.
- req_type, in, 2: 00 = ACT, 01 = WR, 10 = RD; 11 is ignored (accepted, no command).
- req_bg, in, 2: bank group.
- req_ba, in, 2: bank.
- req_row, in, 17: row address.
- req_col, in, 10: column address.
- req_wdata, in, 64: write data; beat n is bits [8n+7:8n].
- req_bl8, in, 1: 1 = BL8, 0 = BL4.
- cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14, out, 1 each: command pins.
- A13, A12_BC_n, A11, A10_AP, out, 1 each: address pins.
- A9_A0, out, 10: address pins.
- bg_addr, out, 2: bank group pins.
- ba_addr, out, 2: bank pins.
- dq_rise, out, 8: byte driven on the rising half of the cycle.
- dq_fall, out, 8: byte driven on the falling half of the cycle.
- dq_oe, out, 1: DQ output enable.
- dqs_en, out, 1: DQS toggling enable (preamble plus burst).
- wr_done, out, 1: one-cycle pulse on the last data cycle.

## Operation
- All outputs are registered. Reset values: cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14 = 1; every other output = 0, except req_ready = 1.
- States and transitions:
  - IDLE → CMD on accept.
  - CMD → TRCD_WAIT (ACT), WR_LAT (WR) or RD_WAIT (RD).
  - WR_LAT → PRE → BURST → IDLE.
  - TRCD_WAIT and RD_WAIT → IDLE when their counters expire.
  - type 11 → IDLE with no command driven.
- req_ready is high only in IDLE.
- Request fields, including wdata and bl8, are latched at accept. Later input changes have no effect on the operation in progress.
- Command encoding {cs_n, act_n, RAS, CAS, WE}:
  - ACT = 00 followed by row[16:14].
  - WR = 01100.
  - RD = 01101.
  - NOP = 11111.
- ACT address mapping: row[13] → A13, row[12] → A12_BC_n, row[11] → A11, row[10] → A10_AP, row[9:0] → A9_A0.
- WR/RD address mapping: col → A9_A0, A12_BC_n = bl8, A10_AP = 0, A13 = A11 = 0.
- bg_addr and ba_addr are valid in every command cycle and 0 on NOP cycles.
- Burst beat order, LSB first: cycle j drives dq_rise = beat 2j and dq_fall = beat 2j+1.
- dq_rise and dq_fall are 0 whenever dq_oe = 0.
- Row and bank state are not checked. Issuing WR or RD to an open row is the scheduler's responsibility.

## Timing
- Accept at edge k; the command is on the pins in cycle C = k+1. All other cycles are NOP.
- ACT: req_ready rises in cycle C+TRCD.
- RD: req_ready rises in cycle C+RD_GAP. No DQ activity.
- WR:
  - Preamble in cycle C+CWL-1 (dqs_en = 1, dq_oe = 0).
  - Data cycles C+CWL through C+CWL+3 for BL8, or C+CWL through C+CWL+1 for BL4 (dqs_en = dq_oe = 1).
  - wr_done pulses on the last data cycle.
  - req_ready rises the cycle after the last data cycle.
- Back-to-back operation: a request waiting when req_ready rises is accepted on that edge, and its command appears on the next cycle. There is no idle bubble beyond this.
- Reset asserted in any state: on the next edge, all outputs take their reset values, any burst in flight is truncated, and the FSM is in IDLE. Reset has priority over an accept on the same edge.

## Configuration
- DDR_CMD_PARITY_EN defined:
  - Adds output PAR (1 bit), placed after WE_n_A14.
  - PAR is registered with the command and equals the XOR of act_n, RAS_n_A16, CAS_n_A15, WE_n_A14, A13–A0, bg_addr and ba_addr, giving even parity.
  - PAR is 0 in reset and on NOP cycles.
- DDR_CMD_PARITY_EN undefined: the port does not exist and there is no parity logic.

## Test plan
- Reset: hold reset for 3 cycles with req_valid = 1 → every output at its reset value, no command issued, req_ready = 1 after release.
- ACT with bg = 2, ba = 1, row = 0x1ABCD → cycle C shows cs_n = 0, act_n = 0, {RAS, CAS, WE} = 110, A13–A10 = 1010, A9_A0 = 0x3CD, bg_addr = 2, ba_addr = 1 → req_ready low for TRCD-1 cycles after C, high at C+4.
- WR BL8 with col = 0x2A8, wdata = 0x8877665544332211, CWL = 9:
  - Cmd bits = 01100, A12_BC_n = 1.
  - Preamble in C+8.
  - Rise/fall pairs (11,22), (33,44), (55,66), (77,88) in C+9 through C+12.
  - wr_done in C+12; ready in C+13.
- WR BL4 with the same data → pairs (11,22), (33,44) only, A12_BC_n = 0, ready in C+11.
- ACT immediately followed by a queued RD → RD command exactly in cycle C_act+TRCD+1. Ready returns 4 cycles after the RD command cycle.
- Reset asserted in C+10 of a BL8 write → dq_oe = dqs_en = 0 and NOP from C+11, no wr_done pulse. With DDR_CMD_PARITY_EN defined, PAR = 1 for the ACT of row 0x00001, bg = ba = 0.
